// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised integer register file with a pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int NUM_READ_PORTS     = 2,
  localparam int REG_DATA_WIDTH    = 32'd1 << REG_DATA_WIDTH_POW,
  localparam int REG_MEM_DEPTH     = 32'd1 << REG_MEM_DEPTH_POW
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic [NUM_READ_PORTS*REG_MEM_DEPTH_POW-1:0] rs_in,
  output logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0]    reg_data_out,
  output logic [NUM_READ_PORTS-1:0]                   rs_busy_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]                rd_in,
  input  logic [REG_DATA_WIDTH-1:0]                   data_write,
  input  logic                                        write_en,
  input  logic [REG_MEM_DEPTH_POW-1:0]                issue_rd_in,
  input  logic                                        issue_en,
  input  logic                                        flush_in
);

  logic [REG_DATA_WIDTH-1:0] regs_r [REG_MEM_DEPTH];
  logic [REG_MEM_DEPTH-1:0]  busy_r;
  logic [REG_MEM_DEPTH-1:0]  busy_nxt_s;
  logic                      wr_hit_s;
  logic                      iss_hit_s;

  assign wr_hit_s  = write_en & (rd_in != '0);
  assign iss_hit_s = issue_en & (issue_rd_in != '0);

  // Architectural registers; x0 is never written so it holds its reset value of zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_MEM_DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_hit_s) begin
      regs_r[rd_in] <= data_write;
    end
  end

  // Scoreboard next state: flush clears everything, an issue overrides a same-register write-back.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush_in) begin
      busy_nxt_s = '0;
    end else begin
      if (wr_hit_s) begin
        busy_nxt_s[rd_in] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (iss_hit_s) begin
        busy_nxt_s[issue_rd_in] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports; reset zeroes the array, so outputs are zero while reset is held.
  always_comb begin
    logic [REG_MEM_DEPTH_POW-1:0] addr_v;
    logic                         nz_v;
    logic                         byp_v;
    reg_data_out = '0;
    rs_busy_out  = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      addr_v = rs_in[p*REG_MEM_DEPTH_POW +: REG_MEM_DEPTH_POW];
      nz_v   = (addr_v != '0);
`ifdef REG_FILE_BYPASS_EN
      byp_v  = wr_hit_s & ~rst_in & (addr_v == rd_in);
      reg_data_out[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] =
        byp_v ? data_write : (nz_v ? regs_r[addr_v] : '0);
      rs_busy_out[p] = ~byp_v & nz_v & busy_r[addr_v];
`else
      byp_v  = 1'b0;
      reg_data_out[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] = nz_v ? regs_r[addr_v] : '0;
      rs_busy_out[p] = ~byp_v & nz_v & busy_r[addr_v];
`endif
    end
  end

endmodule
